// File: rtl/gpu_alu_pkg.sv
// Shared constants and state encoding for the ALU-stage RAM address calculators
// (forward address calculation and its inverse decoder).
package gpu_alu_pkg;

    localparam int ADDR_W          = 27;
    localparam int COORD_W         = 16;
    localparam int FRAME_W         = 8;
    localparam int BYTES_PER_PIXEL = 2;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        DIV_FRAME,
        DIV_ROW,
        DONE
    } addr_dec_state_t;

endpackage

// File: rtl/ram_address_decode_iter_divider.sv
// Unsigned restoring divider, one quotient bit per cycle. The load cycle already
// performs the first step, so a full division occupies exactly DIVIDEND_W cycles.
module iter_divider #(
    parameter int DIVIDEND_W = 26,
    parameter int DIVISOR_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVIDEND_W-1:0] remainder
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic [DIVIDEND_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [DIVISOR_W-1:0]  step_rem;
    logic [DIVISOR_W-1:0]  step_div;
    logic [DIVIDEND_W-1:0] step_acc;
    logic [DIVISOR_W:0]    trial;
    logic [DIVISOR_W:0]    diff;

    assign busy      = (count_q != '0);
    assign quotient  = acc_q;
    // The remainder never exceeds the partial dividend, so it fits the dividend width.
    assign remainder = rem_q[DIVIDEND_W-1:0];

    always_comb begin
        step_rem  = load ? '0 : rem_q;
        step_acc  = load ? dividend : acc_q;
        step_div  = load ? divisor : divisor_q;
        trial     = {step_rem, step_acc[DIVIDEND_W-1]};
        diff      = trial - {1'b0, step_div};

        rem_d     = rem_q;
        acc_d     = acc_q;
        divisor_d = divisor_q;
        count_d   = count_q;

        if (load || busy) begin
            // The top bit of diff is the borrow: set exactly when trial < divisor.
            if (!diff[DIVISOR_W]) begin
                rem_d = diff[DIVISOR_W-1:0];
                acc_d = {step_acc[DIVIDEND_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DIVISOR_W-1:0];
                acc_d = {step_acc[DIVIDEND_W-2:0], 1'b0};
            end
            divisor_d = step_div;
            count_d   = load ? CNT_W'(DIVIDEND_W - 1) : count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem_q     <= '0;
            divisor_q <= '0;
            acc_q     <= '0;
            count_q   <= '0;
        end else begin
            rem_q     <= rem_d;
            divisor_q <= divisor_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/ram_address_decode.sv
// Inverse of the layer RAM address calculation: byte offset -> (frame, row, column)
// for sprites, character index -> first-pixel column for text.
module ram_address_decode #(
    parameter int ADDR_W  = gpu_alu_pkg::ADDR_W,
    parameter int COORD_W = gpu_alu_pkg::COORD_W,
    parameter int FRAME_W = gpu_alu_pkg::FRAME_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               isSprite,
    input  logic [COORD_W-1:0] height,
    input  logic [COORD_W-1:0] width,
    input  logic [ADDR_W-1:0]  addressOffsetBytes,
    output logic               rdy,
    output logic               done,
    output logic               err,
    output logic [FRAME_W-1:0] frameNumber,
    output logic [COORD_W-1:0] layerY,
    output logic [COORD_W-1:0] layerX
);

    import gpu_alu_pkg::*;

    localparam int ALIGN_SH = $clog2(BYTES_PER_PIXEL);
    localparam int PIX_W    = ADDR_W - ALIGN_SH;
    localparam int AREA_W   = 2 * COORD_W;
    localparam int PROD_W   = ADDR_W + COORD_W;

    addr_dec_state_t    state_q, state_d;
    logic               is_sprite_q, is_sprite_d;
    logic [COORD_W-1:0] height_q, height_d;
    logic [COORD_W-1:0] width_q, width_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [FRAME_W-1:0] frame_tmp_q, frame_tmp_d;
    logic               frame_ovf_q, frame_ovf_d;
    logic               err_q, err_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [COORD_W-1:0] layer_y_q, layer_y_d;
    logic [COORD_W-1:0] layer_x_q, layer_x_d;

    logic               div_load;
    logic [PIX_W-1:0]   div_dividend;
    logic [AREA_W-1:0]  div_divisor;
    logic               div_busy;
    logic [PIX_W-1:0]   div_quotient;
    logic [PIX_W-1:0]   div_remainder;

    logic [AREA_W-1:0]  area;
    logic [PROD_W-1:0]  text_product;
    logic               input_err;

    assign area         = AREA_W'(height_q) * AREA_W'(width_q);
    assign text_product = PROD_W'(addr_q) * PROD_W'(width_q);
    assign input_err    = (width_q == '0) ||
                          (is_sprite_q && ((height_q == '0) || (addr_q[ALIGN_SH-1:0] != '0)));

    assign rdy         = (state_q == IDLE);
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign frameNumber = frame_q;
    assign layerY      = layer_y_q;
    assign layerX      = layer_x_q;

    iter_divider #(
        .DIVIDEND_W (PIX_W),
        .DIVISOR_W  (AREA_W)
    ) u_divider (
        .clk       (clk),
        .rst       (rst),
        .load      (div_load),
        .dividend  (div_dividend),
        .divisor   (div_divisor),
        .busy      (div_busy),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

    always_comb begin
        state_d      = state_q;
        is_sprite_d  = is_sprite_q;
        height_d     = height_q;
        width_d      = width_q;
        addr_d       = addr_q;
        frame_tmp_d  = frame_tmp_q;
        frame_ovf_d  = frame_ovf_q;
        err_d        = err_q;
        frame_d      = frame_q;
        layer_y_d    = layer_y_q;
        layer_x_d    = layer_x_q;
        div_load     = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_sprite_d = isSprite;
                    height_d    = height;
                    width_d     = width;
                    addr_d      = addressOffsetBytes;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (input_err) begin
                    err_d     = 1'b1;
                    frame_d   = '0;
                    layer_y_d = '0;
                    layer_x_d = '0;
                    state_d   = DONE;
                end else if (!is_sprite_q) begin
                    err_d     = ((text_product >> COORD_W) != '0);
                    frame_d   = '0;
                    layer_y_d = '0;
                    layer_x_d = err_d ? '0 : text_product[COORD_W-1:0];
                    state_d   = DONE;
                end else begin
                    div_load     = 1'b1;
                    div_dividend = addr_q[ADDR_W-1:ALIGN_SH];
                    div_divisor  = area;
                    state_d      = DIV_FRAME;
                end
            end
            DIV_FRAME: begin
                // The remainder within one frame becomes the dividend of the row division.
                if (!div_busy) begin
                    frame_tmp_d  = div_quotient[FRAME_W-1:0];
                    frame_ovf_d  = ((div_quotient >> FRAME_W) != '0);
                    div_load     = 1'b1;
                    div_dividend = div_remainder;
                    div_divisor  = AREA_W'(width_q);
                    state_d      = DIV_ROW;
                end
            end
            DIV_ROW: begin
                if (!div_busy) begin
                    err_d     = frame_ovf_q;
                    frame_d   = frame_ovf_q ? '0 : frame_tmp_q;
                    layer_y_d = frame_ovf_q ? '0 : div_quotient[COORD_W-1:0];
                    layer_x_d = frame_ovf_q ? '0 : div_remainder[COORD_W-1:0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            is_sprite_q <= 1'b0;
            height_q    <= '0;
            width_q     <= '0;
            addr_q      <= '0;
            frame_tmp_q <= '0;
            frame_ovf_q <= 1'b0;
            err_q       <= 1'b0;
            frame_q     <= '0;
            layer_y_q   <= '0;
            layer_x_q   <= '0;
        end else begin
            state_q     <= state_d;
            is_sprite_q <= is_sprite_d;
            height_q    <= height_d;
            width_q     <= width_d;
            addr_q      <= addr_d;
            frame_tmp_q <= frame_tmp_d;
            frame_ovf_q <= frame_ovf_d;
            err_q       <= err_d;
            frame_q     <= frame_d;
            layer_y_q   <= layer_y_d;
            layer_x_q   <= layer_x_d;
        end
    end

endmodule
